// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Holds the FSM state encoding and the default counter width.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } clk_div_state_t;

   localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter: runs 0..div-1 and wraps, or is held at 0 by clr.
// Ports: clock, rst_n, run, clr, div in; cnt_nxt (next count), wrap out.
module clk_div_cnt
   import clk_div_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic [DIV_W-1:0] cnt_nxt,
   output logic             wrap
);

   localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      wrap  = run && (cnt_q == (div - ONE));
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = wrap ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_nxt = cnt_d;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free divisor reload.
// Ports: clock, rst_n, en, div_in/div_in_valid/div_in_ready (load handshake),
//   div_clk, tick, busy, cfg_err; period_cnt when CLK_DIV_STATUS_EN is defined.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DEF_DIV = 2
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_in_valid,
   output logic             div_in_ready,
   output logic             div_clk,
   output logic             tick,
   output logic             busy,
   output logic             cfg_err
`ifdef CLK_DIV_STATUS_EN
   ,
   output logic [15:0]      period_cnt
`endif
);

   localparam logic [DIV_W-1:0] ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);

   clk_div_state_t   state_q, state_d;
   logic [DIV_W-1:0] div_cur_q, div_cur_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             div_clk_q, div_clk_d;
   logic             tick_q, tick_d;
   logic             cfg_err_q, cfg_err_d;

   logic             run, clr, wrap, accept, apply_pt;
   logic [DIV_W-1:0] cnt_nxt, half;

   assign run = (state_q != IDLE);
   assign clr = (state_q == IDLE);

   clk_div_cnt #(
      .DIV_W (DIV_W)
   ) u_cnt (
      .clock   (clock),
      .rst_n   (rst_n),
      .run     (run),
      .clr     (clr),
      .div     (div_cur_q),
      .cnt_nxt (cnt_nxt),
      .wrap    (wrap)
   );

   always_comb begin
      // Shadow is free exactly when nothing is pending.
      accept    = div_in_valid && !pend_q;
      apply_pt  = pend_q && ((state_q == IDLE) || wrap);
      shadow_d  = accept ? div_in : shadow_q;
      pend_d    = (pend_q && !apply_pt) || accept;
      // A zero divisor is consumed at its apply point but never installed.
      div_cur_d = div_cur_q;
      if (apply_pt && (shadow_q != '0)) begin
         div_cur_d = shadow_q;
      end
      cfg_err_d = cfg_err_q || (accept && (div_in == '0));

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = wrap ? IDLE : DRAIN;
         DRAIN: begin
            if (wrap && !en) state_d = IDLE;
            else if (en)     state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are computed from next-cycle values so they line up
      // with the cycle in which the counter holds that value.
      half = div_cur_d >> 1;
      if (half == '0) half = ONE;
      tick_d    = 1'b0;
      div_clk_d = 1'b0;
      if (state_d != IDLE) begin
         tick_d    = (cnt_nxt == '0);
         div_clk_d = (cnt_nxt < half);
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_cur_q <= DEF_V;
         shadow_q  <= '0;
         pend_q    <= 1'b0;
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cur_q <= div_cur_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         div_clk_q <= div_clk_d;
         tick_q    <= tick_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign div_in_ready = !pend_q;
   assign div_clk      = div_clk_q;
   assign tick         = tick_q;
   assign busy         = (state_q != IDLE);
   assign cfg_err      = cfg_err_q;

`ifdef CLK_DIV_STATUS_EN
   logic [15:0] pcnt_q, pcnt_d;

   always_comb begin
      pcnt_d = pcnt_q;
      if (wrap && (pcnt_q != 16'hFFFF)) begin
         pcnt_d = pcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: vector table plus hand-built
// sequences for drain, zero divisor, reset and period counting.
module tb_clk_div_prog;

   localparam int DIV_W = 8;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             en;
   logic [DIV_W-1:0] div_in;
   logic             div_in_valid;
   logic             div_in_ready;
   logic             div_clk;
   logic             tick;
   logic             busy;
   logic             cfg_err;
`ifdef CLK_DIV_STATUS_EN
   logic [15:0]      period_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   clk_div_prog #(
      .DIV_W   (DIV_W),
      .DEF_DIV (2)
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .en           (en),
      .div_in       (div_in),
      .div_in_valid (div_in_valid),
      .div_in_ready (div_in_ready),
      .div_clk      (div_clk),
      .tick         (tick),
      .busy         (busy),
      .cfg_err      (cfg_err)
`ifdef CLK_DIV_STATUS_EN
      ,
      .period_cnt   (period_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       en;
      logic       vld;
      logic [7:0] div;
      logic       clk_e;
      logic       tick_e;
      logic       rdy_e;
      logic       busy_e;
   } vec_t;

   vec_t vt [23];

   function automatic vec_t mk(input logic e, input logic v, input int d,
                               input logic c, input logic t,
                               input logic r, input logic b);
      vec_t x;
      x.en     = e;
      x.vld    = v;
      x.div    = 8'(d);
      x.clk_e  = c;
      x.tick_e = t;
      x.rdy_e  = r;
      x.busy_e = b;
      return x;
   endfunction

   task automatic step(input logic e, input logic v, input logic [7:0] d);
      en           = e;
      div_in_valid = v;
      div_in       = d;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic c, input logic t,
                      input logic r, input logic b, input logic er);
      n_chk++;
      if ({div_clk, tick, div_in_ready, busy, cfg_err} !== {c, t, r, b, er}) begin
         n_fail++;
         $display("FAIL %s: clk/tick/rdy/busy/err got %b%b%b%b%b want %b%b%b%b%b",
                  nm, div_clk, tick, div_in_ready, busy, cfg_err, c, t, r, b, er);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      div_in_valid = 1'b0;
      div_in = '0;
      #3;
      rst_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   int ticks;

   initial begin
      // N=2 from reset, then N=5 (accepted on a wrap), N=1, N=4.
      vt[0]  = mk(1, 0, 0, 1, 1, 1, 1);
      vt[1]  = mk(1, 0, 0, 0, 0, 1, 1);
      vt[2]  = mk(1, 0, 0, 1, 1, 1, 1);
      vt[3]  = mk(1, 0, 0, 0, 0, 1, 1);
      vt[4]  = mk(1, 1, 5, 1, 1, 0, 1);
      vt[5]  = mk(1, 0, 0, 0, 0, 0, 1);
      vt[6]  = mk(1, 0, 0, 1, 1, 1, 1);
      vt[7]  = mk(1, 0, 0, 1, 0, 1, 1);
      vt[8]  = mk(1, 0, 0, 0, 0, 1, 1);
      vt[9]  = mk(1, 0, 0, 0, 0, 1, 1);
      vt[10] = mk(1, 0, 0, 0, 0, 1, 1);
      vt[11] = mk(1, 0, 0, 1, 1, 1, 1);
      vt[12] = mk(1, 1, 1, 1, 0, 0, 1);
      vt[13] = mk(1, 0, 0, 0, 0, 0, 1);
      vt[14] = mk(1, 0, 0, 0, 0, 0, 1);
      vt[15] = mk(1, 0, 0, 0, 0, 0, 1);
      vt[16] = mk(1, 0, 0, 1, 1, 1, 1);
      vt[17] = mk(1, 1, 4, 1, 1, 0, 1);
      vt[18] = mk(1, 0, 0, 1, 1, 1, 1);
      vt[19] = mk(1, 0, 0, 1, 0, 1, 1);
      vt[20] = mk(1, 0, 0, 0, 0, 1, 1);
      vt[21] = mk(1, 0, 0, 0, 0, 1, 1);
      vt[22] = mk(1, 0, 0, 1, 1, 1, 1);

      rst_n        = 1'b0;
      en           = 1'b1;
      div_in_valid = 1'b0;
      div_in       = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_state", 0, 0, 1, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         step(vt[i].en, vt[i].vld, vt[i].div);
         chk($sformatf("vec%0d", i), vt[i].clk_e, vt[i].tick_e,
             vt[i].rdy_e, vt[i].busy_e, 1'b0);
      end

      // Load 6 while idle, run, drop en at cnt=1, drain to idle.
      do_reset();
      step(0, 1, 6);  chk("idle_accept", 0, 0, 0, 0, 0);
      step(0, 0, 0);  chk("idle_apply", 0, 0, 1, 0, 0);
      step(1, 0, 0);  chk("n6_c0", 1, 1, 1, 1, 0);
      step(1, 0, 0);  chk("n6_c1", 1, 0, 1, 1, 0);
      step(0, 0, 0);  chk("drain_c2", 1, 0, 1, 1, 0);
      step(0, 0, 0);  chk("drain_c3", 0, 0, 1, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);  chk("drain_c5", 0, 0, 1, 1, 0);
      step(0, 0, 0);  chk("drain_idle", 0, 0, 1, 0, 0);

      // Re-raise en during drain: period continues without a gap.
      step(1, 0, 0);  chk("rerun_c0", 1, 1, 1, 1, 0);
      step(1, 0, 0);
      step(0, 0, 0);  chk("redrain_c2", 1, 0, 1, 1, 0);
      step(1, 0, 0);  chk("reraise_c3", 0, 0, 1, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);  chk("reraise_wrap", 1, 1, 1, 1, 0);

      // Divisor 0: handshake completes, error flags, N stays 6.
      step(1, 1, 0);  chk("zero_accept", 1, 0, 0, 1, 1);
      repeat (4) step(1, 0, 0);
      chk("zero_c5", 0, 0, 0, 1, 1);
      step(1, 0, 0);  chk("zero_drop", 1, 1, 1, 1, 1);
      repeat (5) step(1, 0, 0);
      chk("keep6_c5", 0, 0, 1, 1, 1);
      step(1, 0, 0);  chk("keep6_wrap", 1, 1, 1, 1, 1);

      // Reset mid-period with a pending shadow: it must be discarded.
      step(1, 1, 3);  chk("pend3", 1, 0, 0, 1, 1);
      step(1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 0, 0, 1, 0, 0);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1, 0, 0);
         chk($sformatf("post_rst%0d", k), (k % 2) == 0, (k % 2) == 0,
             1'b1, 1'b1, 1'b0);
      end

      // N=3 for 30 cycles: 10 ticks, 10 completed periods.
      do_reset();
      step(0, 1, 3);
      step(0, 0, 0);
      ticks = 0;
      for (int k = 0; k < 30; k++) begin
         step(1, 0, 0);
         if (tick) ticks++;
      end
      n_chk++;
      if (ticks != 10) begin
         n_fail++;
         $display("FAIL n3_ticks: got %0d want 10", ticks);
      end
      step(1, 0, 0);
`ifdef CLK_DIV_STATUS_EN
      n_chk++;
      if (period_cnt !== 16'd10) begin
         n_fail++;
         $display("FAIL period_cnt: got %0d want 10", period_cnt);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
